alu_ref_unit: RTL and testbench

//  Clocked 8-bit ALU with an on-chip golden-result ROM and a compare flag.
//  The ALU registers a result from (op, inp1, inp2) each cycle.
//  The ROM returns the expected result for op code = addr, computed from fixed

---
 rtl/alu_pkg.sv | 54 +++++
 rtl/alu_golden_rom.sv | 37 +++
 rtl/alu_ref_unit.sv | 53 +++++
 tb/tb_alu_ref_unit.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants and the reference ALU function.
// Both the live datapath and the golden ROM evaluate alu_f, so the table
// of expected results always tracks the datapath behaviour.
package alu_pkg;

  localparam int unsigned OP_CODES = 16;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_NAND = 4'd8;
  localparam logic [3:0] OP_NOR  = 4'd9;
  localparam logic [3:0] OP_XNOR = 4'd10;
  localparam logic [3:0] OP_INC  = 4'd11;
  localparam logic [3:0] OP_DEC  = 4'd12;
  localparam logic [3:0] OP_PASA = 4'd13;
  localparam logic [3:0] OP_PASB = 4'd14;
  localparam logic [3:0] OP_ZERO = 4'd15;

  // Operands arrive zero-extended to 32 bits; the caller keeps the low
  // BITS bits of the result, which gives modulo 2**BITS wrap for every op
  // (logical right shift stays correct because the upper bits are zero).
  function automatic logic [31:0] alu_f(input logic [3:0]  op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOT:  r = ~a;
      OP_SHL:  r = a << 1;
      OP_SHR:  r = a >> 1;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      OP_INC:  r = a + 32'd1;
      OP_DEC:  r = a - 32'd1;
      OP_PASA: r = a;
      OP_PASB: r = b;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_golden_rom.sv
// Read-only table of golden ALU results: entry k holds alu_f(k, REF_A, REF_B)
// for the 16 opcodes, all higher entries are zero. Registered read with enable.
module alu_golden_rom
  import alu_pkg::*;
#(
  parameter int BITS  = 8,
  parameter int SIZE  = 6,
  parameter int REF_A = 4,
  parameter int REF_B = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [SIZE-1:0] addr,
  output logic [BITS-1:0] data
);

  logic [BITS-1:0] rom [0:(2**SIZE)-1];

  for (genvar k = 0; k < 2**SIZE; k++) begin : g_rom
    if (k < OP_CODES) begin : g_op
      assign rom[k] = BITS'(alu_f(4'(k), 32'(REF_A), 32'(REF_B)));
    end else begin : g_zero
      assign rom[k] = '0;
    end
  end

  // Registered table read; data holds its value while en is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data <= '0;
    end else if (en) begin
      data <= rom[addr];
    end
  end

endmodule

// File: rtl/alu_ref_unit.sv
// Clocked ALU with a golden-result ROM and a combinational compare flag,
// used as a self-test arithmetic leaf: driving op=addr with the reference
// operands makes out and data agree, raising match.
module alu_ref_unit
  import alu_pkg::*;
#(
  parameter int BITS  = 8,
  parameter int OP    = 4,
  parameter int SIZE  = 6,
  parameter int REF_A = 4,
  parameter int REF_B = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OP-1:0]   op,
  input  logic [BITS-1:0] inp1,
  input  logic [BITS-1:0] inp2,
  input  logic            en,
  input  logic [SIZE-1:0] addr,
  output logic [BITS-1:0] out,
  output logic [BITS-1:0] data,
  output logic            match
);

  logic [BITS-1:0] alu_next;

  assign alu_next = BITS'(alu_f(4'(op), 32'(inp1), 32'(inp2)));

  // ALU result register, one cycle of latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out <= '0;
    end else begin
      out <= alu_next;
    end
  end

  alu_golden_rom #(
    .BITS  (BITS),
    .SIZE  (SIZE),
    .REF_A (REF_A),
    .REF_B (REF_B)
  ) u_rom (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .addr  (addr),
    .data  (data)
  );

  assign match = (out == data);

endmodule

// File: tb/tb_alu_ref_unit.sv
// Self-checking bench for alu_ref_unit: directed corner cases plus a random
// run compared against a plain-arithmetic model of the ALU and golden table.
module tb_alu_ref_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] op;
  logic [7:0] inp1;
  logic [7:0] inp2;
  logic       en;
  logic [5:0] addr;
  logic [7:0] out;
  logic [7:0] data;
  logic       match;

  int n_checks = 0;
  int n_fail   = 0;

  alu_ref_unit dut (
    .clk   (clk),
    .reset (reset),
    .op    (op),
    .inp1  (inp1),
    .inp2  (inp2),
    .en    (en),
    .addr  (addr),
    .out   (out),
    .data  (data),
    .match (match)
  );

  always #5 clk = ~clk;

  // Behavioural model: integer arithmetic reduced modulo 256.
  function automatic int model_alu(int code, int a, int b);
    int r;
    case (code)
      0:  r = a + b;
      1:  r = a - b;
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  r = 255 - a;
      6:  r = a * 2;
      7:  r = a / 2;
      8:  r = 255 - (a & b);
      9:  r = 255 - (a | b);
      10: r = 255 - (a ^ b);
      11: r = a + 1;
      12: r = a - 1;
      13: r = a;
      14: r = b;
      default: r = 0;
    endcase
    return ((r % 256) + 256) % 256;
  endfunction

  function automatic int model_rom(int a);
    return (a < 16) ? model_alu(a, 4, 2) : 0;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_out;
  int exp_data;
  int golden [16] = '{8'h06, 8'h02, 8'h00, 8'h06, 8'h06, 8'hFB, 8'h08, 8'h02,
                      8'hFF, 8'hF9, 8'hF9, 8'h05, 8'h03, 8'h04, 8'h02, 8'h00};

  initial begin
    reset = 1'b1;
    op = 4'd0; inp1 = 8'h11; inp2 = 8'h22; en = 1'b1; addr = 6'd3;
    #2;
    check("por_out", out, 0);
    check("por_data", data, 0);
    check("por_match", match, 1);
    tick();
    check("por_hold_out", out, 0);
    reset = 1'b0;
    tick();
    check("start_out", out, 8'h33);
    check("start_data", data, 8'h06);

    // Sweep of all opcodes against the golden table
    inp1 = 8'h04; inp2 = 8'h02; en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      op = 4'(k); addr = 6'(k);
      tick();
      check($sformatf("sweep_out_%0d", k), out, golden[k]);
      check($sformatf("sweep_data_%0d", k), data, golden[k]);
      check($sformatf("sweep_match_%0d", k), match, 1);
    end

    // Asynchronous reset mid-run, between edges
    op = 4'd0; inp1 = 8'h10; inp2 = 8'h20; addr = 6'd5;
    tick();
    check("pre_rst_out", out, 8'h30);
    #2 reset = 1'b1;
    #1;
    check("rst_async_out", out, 0);
    check("rst_async_data", data, 0);
    check("rst_async_match", match, 1);
    tick();
    check("rst_held_out", out, 0);
    #2 reset = 1'b0;
    #1;
    check("rst_release_out", out, 0);
    check("rst_release_data", data, 0);
    tick();
    check("post_rst_out", out, 8'h30);
    check("post_rst_data", data, 8'hFB);

    // Wrap-around cases
    op = 4'd0; inp1 = 8'hFF; inp2 = 8'h01; tick(); check("wrap_add", out, 8'h00);
    op = 4'd1; inp1 = 8'h00; inp2 = 8'h01; tick(); check("wrap_sub", out, 8'hFF);
    op = 4'd6; inp1 = 8'h80;               tick(); check("wrap_shl", out, 8'h00);
    op = 4'd7; inp1 = 8'h81;               tick(); check("shr_logical", out, 8'h40);
    op = 4'd11; inp1 = 8'hFF;              tick(); check("wrap_inc", out, 8'h00);
    op = 4'd12; inp1 = 8'h00;              tick(); check("wrap_dec", out, 8'hFF);

    // ROM hold while enable is low
    en = 1'b1; addr = 6'd3; tick();
    check("en_load", data, 8'h06);
    en = 1'b0; addr = 6'd5;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("en_hold_%0d", i), data, 8'h06);
    end

    // Out-of-range address and AND pattern
    en = 1'b1; addr = 6'd20; op = 4'd2; inp1 = 8'hF0; inp2 = 8'h3C;
    tick();
    check("rom_hi_zero", data, 8'h00);
    check("and_pattern", out, 8'h30);
    check("match_mismatch", match, 0);
    addr = 6'd63; tick();
    check("rom_top_zero", data, 8'h00);

    // Latency: opcode change between edges is seen only after the next edge
    op = 4'd0; inp1 = 8'h05; inp2 = 8'h03; tick();
    check("lat_add", out, 8'h08);
    #2 op = 4'd4;
    #1;
    check("lat_before_edge", out, 8'h08);
    tick();
    check("lat_after_edge", out, 8'h06);

    // Random run against the model
    exp_data = data;
    for (int i = 0; i < 300; i++) begin
      op   = 4'($urandom_range(0, 15));
      inp1 = 8'($urandom);
      inp2 = 8'($urandom);
      en   = 1'($urandom);
      addr = 6'($urandom);
      exp_out = model_alu(int'(op), int'(inp1), int'(inp2));
      if (en) exp_data = model_rom(int'(addr));
      tick();
      check($sformatf("rnd_out_%0d", i), out, exp_out);
      check($sformatf("rnd_data_%0d", i), data, exp_data);
      check($sformatf("rnd_match_%0d", i), match, (exp_out == exp_data) ? 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
